// File: rtl/sram_arbiter.sv
// Two-requester (IF/DM) arbiter in front of one synchronous SRAM port; DM-priority with IF anti-starvation by default.
// Define SRAM_ARB_RR_EN to replace fixed priority with a 1-bit round-robin pointer.
module sram_arbiter (
    input  logic        clk,
    input  logic        resetn,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_valid,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [1:0]  dm_size,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_gnt,
    output logic        dm_valid,
    output logic        dm_err,
    output logic [31:0] dm_rdata,
    output logic        sram_en,
    output logic [3:0]  sram_wen,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata
);
    localparam int unsigned DW = 32;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_IF   = 2'd1,
        TAG_DM   = 2'd2
    } tag_e;

    tag_e tag_q, tag_d;
    logic err_q, err_d;
    logic zero_q, zero_d;
    logic dm_mis_c;
    logic if_wins_c;
    logic unused_c;

    assign unused_c = ^if_addr[1:0];

    // DM alignment check by access size
    always_comb begin
        dm_mis_c = 1'b0;
        case (dm_size)
            2'b00:   dm_mis_c = 1'b0;
            2'b01:   dm_mis_c = dm_addr[0];
            2'b10:   dm_mis_c = |dm_addr[1:0];
            default: dm_mis_c = 1'b1;
        endcase
    end

`ifdef SRAM_ARB_RR_EN
    // rr_q=1: IF wins the next contested cycle
    logic rr_q, rr_d;

    assign if_wins_c = rr_q;

    always_comb begin
        rr_d = rr_q;
        if (if_gnt)      rr_d = 1'b0;
        else if (dm_gnt) rr_d = 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) rr_q <= 1'b1;
        else         rr_q <= rr_d;
    end
`else
    // boost_q is set one cycle after the counter saturates while IF is still denied
    logic [1:0] starve_q, starve_d;
    logic       boost_q, boost_d;

    assign if_wins_c = boost_q;

    always_comb begin
        starve_d = starve_q;
        boost_d  = boost_q;
        if (!if_req || if_gnt) begin
            starve_d = 2'd0;
            boost_d  = 1'b0;
        end else if (starve_q == 2'd3) begin
            boost_d  = 1'b1;
        end else begin
            starve_d = starve_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            starve_q <= 2'd0;
            boost_q  <= 1'b0;
        end else begin
            starve_q <= starve_d;
            boost_q  <= boost_d;
        end
    end
`endif

    // Issue-cycle grant and SRAM command
    always_comb begin
        if_gnt     = resetn & if_req & (~dm_req | if_wins_c);
        dm_gnt     = resetn & dm_req & ~if_gnt;
        sram_en    = 1'b0;
        sram_wen   = 4'b0000;
        sram_addr  = DW'(0);
        sram_wdata = DW'(0);
        if (if_gnt) begin
            sram_en   = 1'b1;
            sram_addr = {if_addr[31:2], 2'b00};
        end else if (dm_gnt && !dm_mis_c) begin
            sram_en   = 1'b1;
            sram_addr = {dm_addr[31:2], 2'b00};
            if (dm_we) begin
                case (dm_size)
                    2'b00: begin
                        sram_wen   = 4'b0001 << dm_addr[1:0];
                        sram_wdata = {4{dm_wdata[7:0]}};
                    end
                    2'b01: begin
                        sram_wen   = dm_addr[1] ? 4'b1100 : 4'b0011;
                        sram_wdata = {2{dm_wdata[15:0]}};
                    end
                    default: begin
                        sram_wen   = 4'b1111;
                        sram_wdata = dm_wdata;
                    end
                endcase
            end
        end
    end

    always_comb begin
        tag_d  = TAG_NONE;
        err_d  = 1'b0;
        zero_d = 1'b0;
        if (if_gnt) begin
            tag_d = TAG_IF;
        end else if (dm_gnt) begin
            tag_d  = TAG_DM;
            err_d  = dm_mis_c;
            zero_d = dm_mis_c | dm_we;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tag_q  <= TAG_NONE;
            err_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            tag_q  <= tag_d;
            err_q  <= err_d;
            zero_q <= zero_d;
        end
    end

    // Response decode; read data is the raw SRAM word arriving this cycle
    assign if_valid = (tag_q == TAG_IF);
    assign dm_valid = (tag_q == TAG_DM);
    assign dm_err   = dm_valid & err_q;
    assign if_rdata = if_valid ? sram_rdata : DW'(0);
    assign dm_rdata = (dm_valid && !zero_q) ? sram_rdata : DW'(0);

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter with a behavioural synchronous SRAM.
module tb_sram_arbiter;
    logic        clk = 1'b0;
    logic        resetn;
    logic        if_req, if_gnt, if_valid;
    logic [31:0] if_addr, if_rdata;
    logic        dm_req, dm_we, dm_gnt, dm_valid, dm_err;
    logic [1:0]  dm_size;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr, sram_wdata, sram_rdata;

    typedef struct {
        logic        ifv;
        logic        dmv;
        logic        err;
        logic [31:0] rd;
    } rsp_t;

    rsp_t        sbq[$];
    logic [31:0] mem [64];
    int          n_chk = 0;
    int          n_pass = 0;

    sram_arbiter dut (
        .clk(clk), .resetn(resetn),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_size(dm_size), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_valid(dm_valid), .dm_err(dm_err), .dm_rdata(dm_rdata),
        .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous SRAM: read-before-write, byte write enables
    always @(posedge clk) begin
        if (sram_en) begin
            sram_rdata <= mem[sram_addr[7:2]];
            for (int b = 0; b < 4; b++)
                if (sram_wen[b]) mem[sram_addr[7:2]][8*b +: 8] <= sram_wdata[8*b +: 8];
        end
    end

    task automatic check(input string tag, input string what, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s.%s got=0x%08h exp=0x%08h", tag, what, got, exp);
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic we,
                         input logic [1:0] sz, input logic [31:0] da, input logic [31:0] wd);
        if_req = ir; if_addr = ia;
        dm_req = dr; dm_we = we; dm_size = sz; dm_addr = da; dm_wdata = wd;
    endtask

    // g: 0 none, 1 IF, 2 DM; zero: DM response carries rdata=0
    task automatic tick(input string tag, input int g, input logic en, input logic [3:0] wen,
                        input logic [31:0] ad, input logic [31:0] wd, input logic err, input logic zero);
        rsp_t r, n;
        @(negedge clk);
        if (sbq.size() == 0) begin
            check(tag, "sb_empty", 32'd1, 32'd0);
        end else begin
            r = sbq.pop_front();
            check(tag, "if_valid", 32'(if_valid), 32'(r.ifv));
            check(tag, "dm_valid", 32'(dm_valid), 32'(r.dmv));
            check(tag, "dm_err", 32'(dm_err), 32'(r.err));
            if (r.ifv) check(tag, "if_rdata", if_rdata, r.rd);
            if (r.dmv) check(tag, "dm_rdata", dm_rdata, r.rd);
        end
        check(tag, "if_gnt", 32'(if_gnt), 32'(g == 1));
        check(tag, "dm_gnt", 32'(dm_gnt), 32'(g == 2));
        check(tag, "sram_en", 32'(sram_en), 32'(en));
        if (en) begin
            check(tag, "sram_wen", 32'(sram_wen), 32'(wen));
            check(tag, "sram_addr", sram_addr, ad);
            if (wen != 4'b0000) check(tag, "sram_wdata", sram_wdata, wd);
        end
        n.ifv = (g == 1);
        n.dmv = (g == 2);
        n.err = err;
        n.rd  = (g == 1 || (g == 2 && !zero)) ? mem[ad[7:2]] : 32'd0;
        sbq.push_back(n);
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, "if_gnt", 32'(if_gnt), 32'd0);
        check(tag, "dm_gnt", 32'(dm_gnt), 32'd0);
        check(tag, "if_valid", 32'(if_valid), 32'd0);
        check(tag, "dm_valid", 32'(dm_valid), 32'd0);
        check(tag, "dm_err", 32'(dm_err), 32'd0);
        check(tag, "sram_en", 32'(sram_en), 32'd0);
        check(tag, "sram_wen", 32'(sram_wen), 32'd0);
        check(tag, "sram_addr", sram_addr, 32'd0);
        check(tag, "sram_wdata", sram_wdata, 32'd0);
        check(tag, "if_rdata", if_rdata, 32'd0);
        check(tag, "dm_rdata", dm_rdata, 32'd0);
    endtask

    task automatic restart_sb();
        rsp_t z;
        z.ifv = 1'b0; z.dmv = 1'b0; z.err = 1'b0; z.rd = 32'd0;
        sbq.delete();
        sbq.push_back(z);
    endtask

    int pat[8];

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE_0000 | 32'(i * 7);
`ifdef SRAM_ARB_RR_EN
        pat = '{1, 2, 1, 2, 1, 2, 1, 2};
`else
        pat = '{2, 2, 2, 2, 1, 2, 2, 2};
`endif
        resetn = 1'b0;
        drive(1'b1, 32'h4, 1'b1, 1'b1, 2'b10, 32'h8, 32'hFFFF_FFFF);
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        resetn = 1'b1;
        restart_sb();

        drive(1'b1, 32'h0000_0004, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        tick("if_rd", 1, 1'b1, 4'b0000, 32'h4, 32'h0, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b1, 2'b00, 32'h13, 32'h0000_00AB);
        tick("sb13", 2, 1'b1, 4'b1000, 32'h10, 32'hABAB_ABAB, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 1'b1, 1'b1, 2'b00, 32'h11, 32'h1234_565A);
        tick("sb11", 2, 1'b1, 4'b0010, 32'h10, 32'h5A5A_5A5A, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 1'b1, 1'b1, 2'b01, 32'h22, 32'hFFFF_1234);
        tick("sh22", 2, 1'b1, 4'b1100, 32'h20, 32'h1234_1234, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 1'b1, 1'b1, 2'b01, 32'h20, 32'h0000_BEEF);
        tick("sh20", 2, 1'b1, 4'b0011, 32'h20, 32'hBEEF_BEEF, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 1'b1, 1'b1, 2'b10, 32'h30, 32'hDEAD_BEEF);
        tick("sw30", 2, 1'b1, 4'b1111, 32'h30, 32'hDEAD_BEEF, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 2'b10, 32'h30, 32'h0);
        tick("lw30", 2, 1'b1, 4'b0000, 32'h30, 32'h0, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 2'b10, 32'h10, 32'h0);
        tick("lw10", 2, 1'b1, 4'b0000, 32'h10, 32'h0, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 2'b01, 32'h21, 32'h0);
        tick("lh21", 2, 1'b0, 4'b0000, 32'h20, 32'h0, 1'b1, 1'b1);
        drive(1'b0, 32'h0, 1'b1, 1'b1, 2'b10, 32'h32, 32'h5555_5555);
        tick("sw32", 2, 1'b0, 4'b0000, 32'h30, 32'h0, 1'b1, 1'b1);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 2'b11, 32'h40, 32'h0);
        tick("sz11", 2, 1'b0, 4'b0000, 32'h40, 32'h0, 1'b1, 1'b1);

        drive(1'b1, 32'h8, 1'b1, 1'b0, 2'b10, 32'hC, 32'h0);
        for (int i = 0; i < 8; i++)
            tick($sformatf("cont%0d", i), pat[i], 1'b1, 4'b0000, (pat[i] == 1) ? 32'h8 : 32'hC, 32'h0, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        tick("idle", 0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b0, 1'b0);

        drive(1'b0, 32'h0, 1'b1, 1'b0, 2'b10, 32'h30, 32'h0);
        tick("pre_rst", 2, 1'b1, 4'b0000, 32'h30, 32'h0, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        resetn = 1'b0;
        @(negedge clk);
        check_all_zero("mid_rst");
        @(posedge clk); #1;
        resetn = 1'b1;
        restart_sb();
        tick("post_rst0", 0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b0, 1'b0);
        tick("post_rst1", 0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 clk  in  1  single clock; all state updates on its rising edge.
REQ-002 resetn  in  1  asynchronous, active-low reset.
REQ-003 if_req  in  1 / if_addr  in  32  instruction-fetch read request and byte address.
REQ-004 if_gnt  out  1 / if_valid  out  1 / if_rdata  out  32  IF grant (issue cycle), response strobe and data (next cycle).
REQ-005 dm_req  in  1 / dm_we  in  1 / dm_size  in  2 (00 byte, 01 half, 10 word) / dm_addr  in  32 / dm_wdata  in  32  data-memory request, LSB-aligned store data.
REQ-006 dm_gnt  out  1 / dm_valid  out  1 / dm_err  out  1 / dm_rdata  out  32  DM grant, response strobe, misalignment flag, raw read word.
REQ-007 sram_en  out  1 / sram_wen  out  4 / sram_addr  out  32 / sram_wdata  out  32 / sram_rdata  in  32  single shared synchronous SRAM port; read data valid one cycle after sram_en.

Function
REQ-008 The block SHALL issue at most one SRAM access per cycle; grant, sram_en, sram_wen, sram_addr and sram_wdata are combinational in the issue cycle.
REQ-009 sram_addr SHALL be {addr[31:2],2'b00} of the granted requester.
REQ-010 Stores, little-endian: byte -> sram_wen = 4'b0001<<addr[1:0], wdata = {4{wdata[7:0]}}; half -> 4'b0011 (addr[1]=0) or 4'b1100 (addr[1]=1), wdata = {2{wdata[15:0]}}; word -> 4'b1111, wdata unchanged.
REQ-011 Reads SHALL drive sram_wen = 4'b0000; IF requests are always reads.
REQ-012 Misaligned DM access (half with addr[0]=1; word with addr[1:0]!=0; size 11) SHALL be granted without asserting sram_en, and SHALL produce dm_valid=1, dm_err=1 and dm_rdata=0 the next cycle.
REQ-013 A two-bit response tag register (NONE/IF/DM) SHALL record the issue of each cycle; the next cycle asserts if_valid or dm_valid for exactly one cycle, with rdata = sram_rdata (raw word; lane extraction belongs to the MEM stage).
REQ-014 DM stores SHALL also return dm_valid one cycle after grant, with dm_rdata=0.
REQ-015 Back-to-back issue SHALL be allowed: a new grant may occur in the same cycle a response is delivered; throughput is one access per cycle.
REQ-016 Arbitration (default): DM has priority over IF when both request.
REQ-017 A 2-bit starvation counter SHALL increment each cycle IF requests and is denied, and clear on an IF grant or when if_req=0; when it reaches 3, IF SHALL win the next contested cycle, and the counter then clears.
REQ-018 With only one requester active, it SHALL be granted in that cycle; with none, sram_en=0 and the tag records NONE.
REQ-019 Requests SHALL be held by requesters until granted; dropping an ungranted request has no side effect.

Reset
REQ-020 While resetn=0: all grants, valids, dm_err, sram_en and sram_wen = 0; rdata, sram_addr and sram_wdata = 0; tag = NONE; starvation counter = 0; round-robin pointer = IF.
REQ-021 Reset asserted mid-access SHALL discard the pending response; no valid is asserted after deassertion for a pre-reset grant.

Configuration
REQ-022 Macro SRAM_ARB_RR_EN: if defined, contested cycles alternate via a 1-bit round-robin pointer (the last-granted side loses the next contest) and REQ-017 is compiled out; if undefined, REQ-016/REQ-017 apply.

Verification
REQ-023 IF read 0x0000_0004 alone -> if_gnt=1, sram_en=1, sram_addr=0x4, wen=0; next cycle if_valid=1, if_rdata=sram_rdata.
REQ-024 DM sb addr 0x13, wdata 0xAB -> sram_wen=4'b1000, sram_addr=0x10, sram_wdata=0xABABABAB; dm_valid next cycle.
REQ-025 DM lh addr 0x21 -> sram_en=0, dm_gnt=1; next cycle dm_valid=1, dm_err=1, dm_rdata=0.
REQ-026 IF and DM requesting continuously for 8 cycles (macro off) -> grant sequence DM,DM,DM,DM,IF,DM,DM,DM; with SRAM_ARB_RR_EN -> alternating, IF first.
REQ-027 resetn pulled low the cycle after a DM read grant -> no dm_valid after release; all outputs 0 during reset.
